// File: rtl/ctrl_decode_stage_if.sv
// Handshake and control-bundle signals between the fetch/decode register,
// the control decode stage and the execute stage.
interface ctrl_decode_stage_if #(
  parameter int INSTR_W = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr;
  logic [INSTR_W-1:0] pc;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         reg_dest;
  logic [3:0]         alu_op;
  logic               mem_to_reg;
  logic               mem_read;
  logic               mem_write;
  logic               reg_write;
  logic               alu_src;
  logic               sext;
  logic               imm_src;
  logic               jump_sel;
  logic               jump;
  logic [2:0]         branch_sel;
  logic               halt;
  logic               siic;
  logic               rti;

  modport master (
    output in_valid, instr, pc, out_ready,
    input  in_ready, out_valid, reg_dest, alu_op, mem_to_reg, mem_read,
           mem_write, reg_write, alu_src, sext, imm_src, jump_sel, jump,
           branch_sel, halt, siic, rti
  );

  modport slave (
    input  in_valid, instr, pc, out_ready,
    output in_ready, out_valid, reg_dest, alu_op, mem_to_reg, mem_read,
           mem_write, reg_write, alu_src, sext, imm_src, jump_sel, jump,
           branch_sel, halt, siic, rti
  );
endinterface

// File: rtl/ctrl_decode_stage.sv
// Registered control decode stage for the 5-bit-opcode ISA: valid/ready
// buffered control bundle plus the RUN/EXC/HALT machine-state FSM and EPC.
module ctrl_decode_stage #(
  parameter int                 INSTR_W    = 16,
  parameter int                 N_FLUSH    = 2,
  parameter logic [INSTR_W-1:0] EXC_VECTOR = 16'h0002
) (
  input  logic               clk,
  input  logic               rst_n,
  ctrl_decode_stage_if.slave bus,
  input  logic [N_FLUSH-1:0] flush,
  output logic [INSTR_W-1:0] epc,
  output logic               exc_redirect,
  output logic [INSTR_W-1:0] exc_target,
  output logic               halted,
  output logic               exc_active
);

  typedef struct packed {
    logic [1:0] reg_dest;
    logic [3:0] alu_op;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       alu_src;
    logic       sext;
    logic       imm_src;
    logic       jump_sel;
    logic       jump;
    logic [2:0] branch_sel;
    logic       halt;
    logic       siic;
    logic       rti;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = ctrl_t'({2'd2, 4'd0, 5'd0, 1'b1, 3'd0, 3'd0, 3'd0});

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_EXC  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0] state;
  logic [4:0] opcode;
  logic       flush_any;
  logic       in_ready;
  logic       capture;
  logic       out_valid;
  ctrl_t      dec;
  ctrl_t      ctl;

  assign opcode    = bus.instr[INSTR_W-1 -: 5];
  assign flush_any = |flush;
  assign halted    = (state == ST_HALT);
  assign exc_active = (state == ST_EXC);
  assign in_ready  = !halted && (!out_valid || bus.out_ready) && !flush_any;
  assign capture   = bus.in_valid && in_ready;

  always_comb begin
    dec = CTRL_RESET;
    case (opcode[4:2])
      3'b110: begin
        dec.reg_write = 1'b1;
        case (opcode[1:0])
          2'b00: begin
            dec.reg_dest = 2'd0;
            dec.imm_src  = 1'b1;
            dec.alu_src  = 1'b1;
            dec.alu_op   = 4'hD;
          end
          2'b01: begin
            dec.alu_src = 1'b1;
            dec.alu_op  = 4'hF;
          end
          2'b10:   dec.alu_op = {2'b10, bus.instr[1:0]};
          default: dec.alu_op = {2'b00, bus.instr[1:0]};
        endcase
      end
      3'b010: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.reg_dest  = 2'd1;
        dec.alu_op    = {2'b00, opcode[1:0]};
        dec.sext      = ~opcode[1];
      end
      3'b101: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.reg_dest  = 2'd1;
        dec.alu_op    = {2'b10, opcode[1:0]};
      end
      3'b100: begin
        dec.alu_src = 1'b1;
        case (opcode[1:0])
          2'b00: dec.mem_write = 1'b1;
          2'b01: begin
            dec.reg_write  = 1'b1;
            dec.reg_dest   = 2'd1;
            dec.mem_read   = 1'b1;
            dec.mem_to_reg = 1'b1;
          end
          2'b10: begin
            dec.reg_dest  = 2'd0;
            dec.reg_write = 1'b1;
            dec.imm_src   = 1'b1;
            dec.sext      = 1'b0;
            dec.alu_op    = 4'hE;
          end
          default: begin
            dec.reg_dest  = 2'd0;
            dec.reg_write = 1'b1;
            dec.mem_write = 1'b1;
          end
        endcase
      end
      3'b011: begin
        dec.imm_src    = 1'b1;
        dec.branch_sel = opcode[2:0];
      end
      3'b001: begin
        // Linking jumps (op[1]=1) write the return address into R7.
        dec.jump      = 1'b1;
        dec.jump_sel  = opcode[0];
        dec.reg_write = opcode[1];
        dec.reg_dest  = opcode[1] ? 2'd3 : 2'd2;
        dec.alu_src   = 1'b1;
        dec.imm_src   = 1'b1;
      end
      3'b111: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = {1'b0, opcode[2:0]};
      end
      default: begin
        dec.halt = (opcode[1:0] == 2'b00);
        dec.siic = (opcode[1:0] == 2'b10);
        dec.rti  = (opcode[1:0] == 2'b11);
      end
    endcase
  end

  // Flush outranks everything, including a stalled bundle awaiting out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ctl       <= CTRL_RESET;
    end else if (flush_any) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      ctl       <= dec;
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Machine state only advances on a captured (hence unflushed) instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_RUN;
      epc          <= '0;
      exc_redirect <= 1'b0;
      exc_target   <= '0;
    end else begin
      exc_redirect <= 1'b0;
      if (capture) begin
        case (state)
          ST_RUN: begin
            if (dec.halt) begin
              state <= ST_HALT;
            end else if (dec.siic) begin
              state        <= ST_EXC;
              epc          <= bus.pc + INSTR_W'(2);
              exc_redirect <= 1'b1;
              exc_target   <= EXC_VECTOR;
            end
          end
          ST_EXC: begin
            if (dec.halt || dec.siic) begin
              state <= ST_HALT;
            end else if (dec.rti) begin
              state        <= ST_RUN;
              exc_redirect <= 1'b1;
              exc_target   <= epc;
            end
          end
          ST_HALT: state <= ST_HALT;
          default: state <= ST_RUN;
        endcase
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.reg_dest   = ctl.reg_dest;
  assign bus.alu_op     = ctl.alu_op;
  assign bus.mem_to_reg = ctl.mem_to_reg;
  assign bus.mem_read   = ctl.mem_read;
  assign bus.mem_write  = ctl.mem_write;
  assign bus.reg_write  = ctl.reg_write;
  assign bus.alu_src    = ctl.alu_src;
  assign bus.sext       = ctl.sext;
  assign bus.imm_src    = ctl.imm_src;
  assign bus.jump_sel   = ctl.jump_sel;
  assign bus.jump       = ctl.jump;
  assign bus.branch_sel = ctl.branch_sel;
  assign bus.halt       = ctl.halt;
  assign bus.siic       = ctl.siic;
  assign bus.rti        = ctl.rti;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Scoreboard bench for ctrl_decode_stage: a behavioural model predicts each
// accepted bundle and machine state; a negedge monitor compares the DUT.
`timescale 1ns/1ps
module tb_ctrl_decode_stage;

  localparam int          W   = 16;
  localparam logic [15:0] VEC = 16'h0002;
  localparam logic [20:0] RESET_BUNDLE = {2'd2, 4'd0, 5'd0, 1'b1, 3'd0, 3'd0, 3'd0};

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [1:0]   flush;
  logic [W-1:0] epc;
  logic         exc_redirect;
  logic [W-1:0] exc_target;
  logic         halted;
  logic         exc_active;

  ctrl_decode_stage_if #(.INSTR_W(W)) bus ();

  ctrl_decode_stage #(.INSTR_W(W), .N_FLUSH(2), .EXC_VECTOR(VEC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .flush        (flush),
    .epc          (epc),
    .exc_redirect (exc_redirect),
    .exc_target   (exc_target),
    .halted       (halted),
    .exc_active   (exc_active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the stage is a one-entry buffer plus a machine mode.
  logic [20:0] sb_q[$];
  bit          m_occ    = 1'b0;
  bit          m_halted = 1'b0;
  bit          m_exc    = 1'b0;
  bit          m_redir  = 1'b0;
  logic [15:0] m_epc    = '0;
  logic [15:0] m_target = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [20:0] refDecode(input logic [15:0] ins);
    int op, grp, sub, lo, rd, alu, br;
    bit m2r, mr, mw, rw, as, sx, is, js, j, h, s, r;
    op  = int'(ins[15:11]);
    grp = op / 4;
    sub = op % 4;
    lo  = int'(ins[1:0]);
    rd = 2; alu = 0; br = 0; sx = 1'b1;
    m2r = 0; mr = 0; mw = 0; rw = 0; as = 0; is = 0; js = 0; j = 0; h = 0; s = 0; r = 0;
    if (grp == 6) begin
      rw = 1'b1;
      if (sub == 0) begin rd = 0; is = 1'b1; as = 1'b1; alu = 13; end
      else if (sub == 1) begin as = 1'b1; alu = 15; end
      else if (sub == 2) alu = 8 + lo;
      else alu = lo;
    end else if (grp == 2) begin
      rw = 1'b1; as = 1'b1; rd = 1; alu = sub; sx = (sub < 2);
    end else if (grp == 5) begin
      rw = 1'b1; as = 1'b1; rd = 1; alu = 8 + sub;
    end else if (grp == 4) begin
      as = 1'b1;
      if (sub == 0) mw = 1'b1;
      else if (sub == 1) begin rw = 1'b1; rd = 1; mr = 1'b1; m2r = 1'b1; end
      else if (sub == 2) begin rd = 0; rw = 1'b1; is = 1'b1; sx = 1'b0; alu = 14; end
      else begin rd = 0; rw = 1'b1; mw = 1'b1; end
    end else if (grp == 3) begin
      is = 1'b1; br = op % 8;
    end else if (grp == 1) begin
      j = 1'b1; js = (sub % 2 == 1); rw = (sub >= 2); rd = (sub >= 2) ? 3 : 2; as = 1'b1; is = 1'b1;
    end else if (grp == 7) begin
      rw = 1'b1; alu = op % 8;
    end else begin
      h = (op == 0); s = (op == 2); r = (op == 3);
    end
    return {2'(rd), 4'(alu), m2r, mr, mw, rw, as, sx, is, js, j, 3'(br), h, s, r};
  endfunction

  function automatic logic [20:0] packDut();
    return {bus.reg_dest, bus.alu_op, bus.mem_to_reg, bus.mem_read, bus.mem_write,
            bus.reg_write, bus.alu_src, bus.sext, bus.imm_src, bus.jump_sel, bus.jump,
            bus.branch_sel, bus.halt, bus.siic, bus.rti};
  endfunction

  function automatic bit modelReady();
    return !m_halted && (!m_occ || bus.out_ready) && !(|flush);
  endfunction

  task automatic stepModel();
    bit acc;
    int op;
    acc = bus.in_valid && modelReady();
    op  = int'(bus.instr[15:11]);
    m_redir = 1'b0;
    if (|flush) begin
      m_occ = 1'b0;
    end else if (acc) begin
      m_occ = 1'b1;
      sb_q.push_back(refDecode(bus.instr));
      if (op == 0) begin
        m_halted = 1'b1; m_exc = 1'b0;
      end else if (op == 2) begin
        if (m_exc) begin
          m_halted = 1'b1; m_exc = 1'b0;
        end else begin
          m_epc = bus.pc + 16'd2; m_exc = 1'b1; m_redir = 1'b1; m_target = VEC;
        end
      end else if (op == 3 && m_exc) begin
        m_exc = 1'b0; m_redir = 1'b1; m_target = m_epc;
      end
    end else if (bus.out_ready) begin
      m_occ = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      sb_q.delete();
      m_occ = 1'b0; m_halted = 1'b0; m_exc = 1'b0; m_redir = 1'b0;
      m_epc = '0; m_target = '0;
    end else begin
      stepModel();
    end
  end

  // Monitor: compares every cycle, pops when the held bundle leaves or is flushed.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      checkOutput("in_ready", 32'(bus.in_ready), 32'(modelReady()));
      checkOutput("out_valid", 32'(bus.out_valid), 32'(m_occ));
      checkOutput("halted", 32'(halted), 32'(m_halted));
      checkOutput("exc_active", 32'(exc_active), 32'(m_exc));
      checkOutput("epc", 32'(epc), 32'(m_epc));
      checkOutput("exc_redirect", 32'(exc_redirect), 32'(m_redir));
      if (m_redir) checkOutput("exc_target", 32'(exc_target), 32'(m_target));
      if (m_occ) begin
        if (sb_q.size() == 0) begin
          checkOutput("sb_depth", 32'(sb_q.size()), 32'd1);
        end else begin
          checkOutput("bundle", 32'(packDut()), 32'(sb_q[0]));
          if (bus.out_ready || (|flush)) void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [15:0] ins, input logic [15:0] p,
                               input logic [1:0] fl, input logic rdy);
    bus.in_valid  = v;
    bus.instr     = ins;
    bus.pc        = p;
    flush         = fl;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_bundle", 32'(packDut()), 32'(RESET_BUNDLE));
    checkOutput("rst_epc", 32'(epc), 32'd0);
    checkOutput("rst_redirect", 32'(exc_redirect), 32'd0);
    checkOutput("rst_target", 32'(exc_target), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    checkOutput("rst_exc_active", 32'(exc_active), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [4:0]  opv;
    logic [15:0] ins;
    logic [15:0] p;
    logic [1:0]  fl;
    bus.in_valid = 1'b0; bus.instr = '0; bus.pc = '0; bus.out_ready = 1'b0; flush = '0;
    #2;
    doReset();

    // SUB then back-to-back issue
    applyStimulus(1'b1, 16'hD841, 16'h0000, 2'b00, 1'b1);
    checkOutput("sub_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("sub_alu_op", 32'(bus.alu_op), 32'd1);
    checkOutput("sub_reg_write", 32'(bus.reg_write), 32'd1);
    checkOutput("sub_reg_dest", 32'(bus.reg_dest), 32'd2);
    checkOutput("sub_alu_src", 32'(bus.alu_src), 32'd0);
    applyStimulus(1'b1, 16'h4123, 16'h0002, 2'b00, 1'b1);
    applyStimulus(1'b1, 16'hA005, 16'h0004, 2'b00, 1'b1);
    applyStimulus(1'b1, 16'hE000, 16'h0006, 2'b00, 1'b1);

    // LD held under back-pressure
    applyStimulus(1'b1, 16'h8800, 16'h0008, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 16'hD841, 16'h000A, 2'b00, 1'b0);
      checkOutput("ld_stall_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("ld_stall_mem_read", 32'(bus.mem_read), 32'd1);
      checkOutput("ld_stall_reg_dest", 32'(bus.reg_dest), 32'd1);
    end
    applyStimulus(1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1);
    checkOutput("ld_drained", 32'(bus.out_valid), 32'd0);

    // SIIC / RTI round trip
    applyStimulus(1'b1, 16'h1000, 16'h0040, 2'b00, 1'b1);
    checkOutput("siic_epc", 32'(epc), 32'h0042);
    checkOutput("siic_exc_active", 32'(exc_active), 32'd1);
    checkOutput("siic_redirect", 32'(exc_redirect), 32'd1);
    checkOutput("siic_target", 32'(exc_target), 32'h0002);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1);
    checkOutput("siic_pulse_end", 32'(exc_redirect), 32'd0);
    applyStimulus(1'b1, 16'h1800, 16'h0044, 2'b00, 1'b1);
    checkOutput("rti_redirect", 32'(exc_redirect), 32'd1);
    checkOutput("rti_target", 32'(exc_target), 32'h0042);
    checkOutput("rti_exc_active", 32'(exc_active), 32'd0);

    // Flushes: stalled bundle dropped, flushed SIIC has no effect, pc wrap
    doReset();
    applyStimulus(1'b1, 16'h8800, 16'h0000, 2'b00, 1'b0);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 2'b01, 1'b0);
    checkOutput("flush_drop", 32'(bus.out_valid), 32'd0);
    applyStimulus(1'b1, 16'h1000, 16'h0050, 2'b10, 1'b1);
    checkOutput("flush_siic_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("flush_siic_epc", 32'(epc), 32'd0);
    checkOutput("flush_siic_redirect", 32'(exc_redirect), 32'd0);
    checkOutput("flush_siic_exc", 32'(exc_active), 32'd0);
    applyStimulus(1'b1, 16'h1000, 16'hFFFE, 2'b00, 1'b1);
    checkOutput("wrap_epc", 32'(epc), 32'h0000);
    checkOutput("wrap_exc_active", 32'(exc_active), 32'd1);
    applyStimulus(1'b1, 16'h1800, 16'h0002, 2'b00, 1'b1);
    checkOutput("wrap_rti_target", 32'(exc_target), 32'h0000);

    // RTI in RUN is a NOP; nested SIIC halts
    applyStimulus(1'b1, 16'h1800, 16'h0010, 2'b00, 1'b1);
    checkOutput("run_rti_flag", 32'(bus.rti), 32'd1);
    checkOutput("run_rti_redirect", 32'(exc_redirect), 32'd0);
    applyStimulus(1'b1, 16'h1000, 16'h0020, 2'b00, 1'b1);
    applyStimulus(1'b1, 16'h1000, 16'h0030, 2'b00, 1'b1);
    checkOutput("nested_halted", 32'(halted), 32'd1);
    checkOutput("nested_epc", 32'(epc), 32'h0022);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1);
    doReset();

    // HALT held, then asynchronous reset mid-stall
    applyStimulus(1'b1, 16'h0000, 16'h0060, 2'b00, 1'b0);
    checkOutput("halt_halted", 32'(halted), 32'd1);
    checkOutput("halt_bundle", 32'(bus.halt), 32'd1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 16'hD841, 16'h0062, 2'b00, 1'b0);
      checkOutput("halt_in_ready", 32'(bus.in_ready), 32'd0);
    end
    applyStimulus(1'b1, 16'hD841, 16'h0064, 2'b00, 1'b1);
    doReset();

    // Randomized traffic
    for (int c = 0; c < 900; c++) begin
      if (m_halted && !m_occ) doReset();
      opv = 5'($urandom_range(0, 31));
      if (opv == 5'd0 && $urandom_range(0, 3) != 0) opv = 5'd1;
      ins = {opv, 11'($urandom)};
      p   = ($urandom_range(0, 15) == 0) ? 16'hFFFE : (16'($urandom) & 16'hFFFE);
      fl  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      applyStimulus(1'($urandom_range(0, 3) != 0), ins, p, fl, 1'($urandom_range(0, 3) != 0));
    end
    applyStimulus(1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ctrl_decode_stage.md
Name: ctrl_decode_stage

Overview:
- Registered, parametrised successor to the combinational instruction-control decoder of the 5-bit-opcode ISA.
- Sits between the fetch/decode pipeline register and the execute stage. Decodes one instruction per handshake into a registered control bundle.
- Handles valid/ready back-pressure and per-source flushes.
- Owns a small machine-state FSM for HALT and the SIIC/RTI exception sequence, including the EPC register.

Parameters:
- INSTR_W, 16, instruction and PC width (≥16; opcode is always instr[INSTR_W-1 -: 5]).
- N_FLUSH, 2, number of independent flush sources.
- EXC_VECTOR, 16'h0002, handler address driven on exc_target when SIIC retires.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept.
- instr  in  INSTR_W  instruction word.
- pc  in  INSTR_W  address of instr.
- flush  in  N_FLUSH  any bit set kills the in-flight and incoming instruction.
- out_valid  out  1  control bundle valid.
- out_ready  in  1  execute stage accepts.
- reg_dest  out  2  0=rs field, 1=rt-I field, 2=rd field, 3=R7.
- alu_op  out  4  ALU operation.
- mem_to_reg, mem_read, mem_write, reg_write, alu_src, sext, imm_src, jump_sel, jump  out  1 each  datapath controls.
- branch_sel  out  3  0=not a branch, else opcode[2:0].
- halt, siic, rti  out  1 each  decoded system ops.
- epc  out  INSTR_W  saved return PC.
- exc_redirect  out  1  one-cycle pulse requesting fetch redirect.
- exc_target  out  INSTR_W  redirect target.
- halted  out  1  machine stopped.
- exc_active  out  1  inside handler.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, all bundle outputs 0 except reg_dest=2 and sext=1, epc=0, exc_redirect=0, exc_target=0, halted=0, exc_active=0, FSM=RUN.
- Decode is combinational from opcode=instr[top 5 bits]. Defaults match the reset values. The decode table:
  - 110xx R-group:
    - 11000 LBI: reg_dest=0, reg_write, imm_src, alu_src, alu_op=D.
    - 11001 BTR: alu_src, reg_write, alu_op=F.
    - 11010 shifts: reg_write, alu_op={10,instr[1:0]}.
    - 11011 arithmetic: reg_write, alu_op={00,instr[1:0]}.
  - 010xx I-arith: reg_write, alu_src, reg_dest=1, alu_op={00,op[1:0]}, sext=~op[1].
  - 101xx I-shift: reg_write, alu_src, reg_dest=1, alu_op={10,op[1:0]}.
  - 100xx memory/SLBI:
    - 10000 ST: mem_write, alu_src.
    - 10001 LD: reg_write, reg_dest=1, mem_read, mem_to_reg, alu_src.
    - 10010 SLBI: reg_dest=0, reg_write, alu_src, imm_src, sext=0, alu_op=E.
    - 10011 STU: reg_dest=0, reg_write, mem_write, alu_src.
  - 011xx branch: imm_src, branch_sel=op[2:0].
  - 001xx jump: jump, jump_sel=op[0], reg_write=op[1], reg_dest=op[1]?3:2, alu_src, imm_src.
  - 111xx SET: reg_write, alu_op={0,op[2:0]}.
  - 000xx system: 00000 halt, 00001 NOP, 00010 siic, 00011 rti.
- Handshake:
  - in_ready = !halted && (!out_valid || out_ready) && !(|flush).
  - Capture happens when in_valid && in_ready: the bundle is registered and out_valid=1 next cycle. Latency is 1 cycle.
  - If out_valid && out_ready with no capture, out_valid goes to 0.
  - If out_valid && !out_ready, the bundle holds stable.
- Flush (any bit, highest priority): out_valid←0 next cycle and no capture this cycle. A flushed instruction causes no FSM transition, no EPC write and no redirect.
- FSM: states RUN, EXC and HALT. Transitions occur at capture of the decoded instruction.
  - RUN, halt captured: →HALT next cycle and halted=1. The HALT bundle is still presented once on out_valid.
  - RUN, siic captured: epc←pc+2 (INSTR_W wrap-around), →EXC, exc_active=1, exc_redirect=1 for exactly one cycle with exc_target=EXC_VECTOR.
  - EXC, rti captured: →RUN, exc_active=0, exc_redirect pulse with exc_target=epc.
  - EXC, siic captured (nested): treated as halt, →HALT. epc is unchanged.
  - RUN, rti captured: the stage outputs rti=1 but the FSM takes no action. It is treated as a NOP (no redirect).
  - EXC, halt captured: →HALT.
  - HALT: absorbing until reset. in_ready=0 and remaining out_valid drains normally.
- Simultaneous events:
  - Flush with in_valid: the flush wins.
  - Flush while a bundle is stalled: the bundle is dropped.
- Reset mid-operation: returns to RUN immediately (async); epc is cleared.

Test Plan:
- Reset release, in_valid=1, instr=16'hD841 (SUB), out_ready=1 → next cycle out_valid=1, alu_op=1, reg_write=1, reg_dest=2, alu_src=0. Back-to-back issue at 1 instr/cycle.
- instr=16'h8800 (LD), out_ready held 0 for 3 cycles → in_ready=0 and mem_read/mem_to_reg/reg_dest=1 stable for 3 cycles. Bundle transfers on the 4th cycle.
- pc=16'h0040, instr=16'h1000 (SIIC) → epc=16'h0042, exc_active=1, one-cycle exc_redirect with target 16'h0002. Then instr=16'h1800 (RTI) → redirect to 16'h0042, exc_active=0.
- SIIC accepted with flush=2'b10 in the same cycle → out_valid=0, epc stays 0, no redirect. With pc=16'hFFFE unflushed → epc=16'h0000 (wrap).
- instr=16'h0000 (HALT) → halt bundle emitted once, halted=1, in_ready=0 forever. Pulse rst_n low mid-stall → all outputs return to reset values asynchronously.
- RTI in RUN state and nested SIIC in EXC state → rti=1 with no redirect; nested SIIC → halted=1, epc unchanged.
